// File: rtl/hazard_stall.sv
// Stall/flush control for the 5-stage pipeline: load-use bubble, taken-branch flush, data-memory freeze with timeout.
// Latency: stall/flush outputs are combinational from the current state and inputs; MemErr and the counters are registered (1 cycle).
// Backpressure: a pending memory access (req without ready) freezes F/D/E/M and drains W; the freeze is released on ready or on timeout.
module hazard_stall #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32,
    parameter int TO_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic [2:0]       RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Wait-counter value at which a still-unanswered access is abandoned.
    localparam logic [TO_W-1:0]  LP_LAST_WAIT = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [1:0]       LP_SRC_LOAD  = 2'b01;

    state_t           r_state;
    logic [TO_W-1:0]  r_waitcnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lw_stall;
    logic w_timeout;
    logic w_mem_hold;
    logic w_stall_f;
    logic w_stall_d;
    logic w_stall_e;
    logic w_stall_m;
    logic w_flush_d;
    logic w_flush_e;
    logic w_flush_w;

    // Hazard terms: load result needed by the Decode instruction, and memory access still outstanding.
    always_comb begin
        w_lw_stall = (ResultSrcE == LP_SRC_LOAD) && (RegWriteE != 3'd0) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
        w_timeout  = (r_state == MEM_WAIT) && (r_waitcnt == LP_LAST_WAIT) && !MemReadyM;
        w_mem_hold = ((r_state == IDLE) && MemReqM && !MemReadyM) ||
                     ((r_state == MEM_WAIT) && !MemReadyM && !w_timeout);
    end

    // Prioritised stall/flush decode; reset forces everything quiet so the pipeline registers clear cleanly.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (rst) begin
            if (w_mem_hold) begin
                // Full freeze; branch and load-use are re-evaluated once memory releases.
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_stall_m = 1'b1;
                w_flush_w = 1'b1;
            end else if (PCSrcE) begin
                // The Decode instruction is wrong-path, so a pending load-use on it is moot.
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_lw_stall) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_e = 1'b1;
            end
        end
    end

    // Memory-wait FSM with wait counter and one-cycle registered error pulse on abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_waitcnt <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            case (r_state)
                IDLE: begin
                    if (MemReqM && !MemReadyM) begin
                        r_state   <= MEM_WAIT;
                        r_waitcnt <= TO_W'(1);
                    end else begin
                        r_waitcnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    // MemReqM is held by the frozen M stage, so only ready and the counter matter here.
                    if (MemReadyM || w_timeout) begin
                        r_state   <= IDLE;
                        r_waitcnt <= '0;
                    end else begin
                        r_waitcnt <= r_waitcnt + TO_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_waitcnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counter of cycles spent holding the PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_f && (r_stall_cnt != LP_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Saturating performance counter of bubbles inserted into Execute.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_cnt <= '0;
        end else if (w_flush_e && (r_flush_cnt != LP_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign StallF     = w_stall_f;
    assign StallD     = w_stall_d;
    assign StallE     = w_stall_e;
    assign StallM     = w_stall_m;
    assign FlushD     = w_flush_d;
    assign FlushE     = w_flush_e;
    assign FlushW     = w_flush_w;
    assign MemErr     = r_mem_err;
    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall.sv
// Bench for hazard_stall: directed scenarios plus a randomized run against a cycle-level reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The model tracks how long the current memory access has been outstanding rather than an FSM state.
module tb_hazard_stall;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, RdE;
    logic [2:0]    RegWriteE;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCount, FlushCount;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: age of the outstanding access (0 = none), pending error pulse, counters.
    int            m_age  = 0;
    logic          m_err  = 1'b0;
    logic [CW-1:0] m_scnt = '0;
    logic [CW-1:0] m_fcnt = '0;

    logic [6:0] obs;
    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    localparam logic [6:0] P_HOLD   = 7'b1111001;
    localparam logic [6:0] P_BRANCH = 7'b0000110;
    localparam logic [6:0] P_LOAD   = 7'b1100010;
    localparam logic [6:0] P_NONE   = 7'b0000000;

    always #5 clk = ~clk;

    hazard_stall #(.TIMEOUT(TO), .CNT_W(CW), .TO_W(TW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Expected combinational outputs: an access is held while it has been outstanding
    // for fewer than TO-1 cycles; at age TO-1 without ready it is abandoned.
    function automatic logic [6:0] exp_comb();
        logic lw;
        logic hold;
        if (!rst) return P_NONE;
        lw   = (ResultSrcE == 2'b01) && (RegWriteE != 3'd0) && (RdE != 5'd0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
        hold = ((m_age > 0) || MemReqM) && !MemReadyM && (m_age < TO - 1);
        if (hold)   return P_HOLD;
        if (PCSrcE) return P_BRANCH;
        if (lw)     return P_LOAD;
        return P_NONE;
    endfunction

    // Advance one clock edge and the reference model with it.
    task automatic tick();
        logic [6:0] e;
        @(posedge clk);
        e = exp_comb();
        if (!rst) begin
            m_age  = 0;
            m_err  = 1'b0;
            m_scnt = '0;
            m_fcnt = '0;
        end else begin
            if (e[6] && (m_scnt != {CW{1'b1}})) m_scnt = m_scnt + 1'b1;
            if (e[1] && (m_fcnt != {CW{1'b1}})) m_fcnt = m_fcnt + 1'b1;
            m_err = (m_age == TO - 1) && !MemReadyM;
            m_age = e[0] ? m_age + 1 : 0;
        end
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b1; Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0; RegWriteE = 3'd0;
        ResultSrcE = 2'd0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic set_load_use();
        ResultSrcE = 2'b01; RegWriteE = 3'b001; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd7;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0; MemReqM = 1'b1; PCSrcE = 1'b1; set_load_use();
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE) begin
            miscompares++; $display("FAIL reset_comb: got %b want %b", obs, P_NONE);
        end
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (StallCount !== '0 || FlushCount !== '0 || MemErr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs: got scnt=%0d fcnt=%0d err=%b want 0 0 0", StallCount, FlushCount, MemErr);
        end
        rst = 1'b1;
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        @(negedge clk);
        vectors++;
        if (obs !== P_LOAD) begin
            miscompares++; $display("FAIL load_use: got %b want %b", obs, P_LOAD);
        end
        tick();
        set_idle();
        @(negedge clk);
        vectors++;
        if (StallCount !== 4'd1 || FlushCount !== 4'd1) begin
            miscompares++; $display("FAIL load_use_cnt: got %0d/%0d want 1/1", StallCount, FlushCount);
        end
        set_load_use(); RdE = 5'd0;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE) begin
            miscompares++; $display("FAIL load_use_rd0: got %b want %b", obs, P_NONE);
        end
        Rs1D = 5'd0;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE) begin
            miscompares++; $display("FAIL load_use_rd0_rs0: got %b want %b", obs, P_NONE);
        end
        set_idle();
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use(); PCSrcE = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== P_BRANCH) begin
            miscompares++; $display("FAIL branch_over_load: got %b want %b", obs, P_BRANCH);
        end
        tick();
        set_idle();
        @(negedge clk);
        vectors++;
        if (StallCount !== 4'd0 || FlushCount !== 4'd1) begin
            miscompares++; $display("FAIL branch_cnt: got %0d/%0d want 0/1", StallCount, FlushCount);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== P_NONE) begin
                miscompares++; $display("FAIL zero_wait_%0d: got %b want %b", i, obs, P_NONE);
            end
            tick();
        end
        // Still idle: with no request, a missing ready must not stall.
        MemReqM = 1'b0; MemReadyM = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE) begin
            miscompares++; $display("FAIL zero_wait_idle: got %b want %b", obs, P_NONE);
        end
    endtask

    task automatic test_mem_3cycle();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== P_HOLD) begin
                miscompares++; $display("FAIL mem3_hold_%0d: got %b want %b", i, obs, P_HOLD);
            end
            tick();
        end
        MemReadyM = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE) begin
            miscompares++; $display("FAIL mem3_ready: got %b want %b", obs, P_NONE);
        end
        tick();
        MemReqM = 1'b0; MemReadyM = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE || StallCount !== 4'd3 || MemErr !== 1'b0) begin
            miscompares++;
            $display("FAIL mem3_after: got %b scnt=%0d err=%b want %b 3 0", obs, StallCount, MemErr, P_NONE);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        // Request cycle plus waits until the counter reaches TO-1: TO-1 frozen cycles.
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== P_HOLD || MemErr !== 1'b0) begin
                miscompares++; $display("FAIL timeout_hold_%0d: got %b err=%b want %b 0", i, obs, MemErr, P_HOLD);
            end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE || MemErr !== 1'b0) begin
            miscompares++; $display("FAIL timeout_abort: got %b err=%b want %b 0", obs, MemErr, P_NONE);
        end
        tick();
        MemReqM = 1'b0;
        @(negedge clk);
        vectors++;
        if (MemErr !== 1'b1 || obs !== P_NONE) begin
            miscompares++; $display("FAIL timeout_err: got err=%b %b want 1 %b", MemErr, obs, P_NONE);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (MemErr !== 1'b0 || StallCount !== 4'(TO - 1)) begin
            miscompares++; $display("FAIL timeout_after: got err=%b scnt=%0d want 0 %0d", MemErr, StallCount, TO - 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick();
        tick();
        @(negedge clk);
        vectors++;
        if (StallCount !== 4'd2 || obs !== P_HOLD) begin
            miscompares++; $display("FAIL midwait_pre: got scnt=%0d %b want 2 %b", StallCount, obs, P_HOLD);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE) begin
            miscompares++; $display("FAIL midwait_rst_comb: got %b want %b", obs, P_NONE);
        end
        tick();
        rst = 1'b1; MemReqM = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== P_NONE || StallCount !== 4'd0 || FlushCount !== 4'd0 || MemErr !== 1'b0) begin
            miscompares++;
            $display("FAIL midwait_after: got %b %0d %0d err=%b want %b 0 0 0", obs, StallCount, FlushCount, MemErr, P_NONE);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (MemErr !== 1'b0) begin
            miscompares++; $display("FAIL midwait_noerr: got %b want 0", MemErr);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        set_idle();
        @(negedge clk);
        vectors++;
        if (StallCount !== 4'd15 || FlushCount !== 4'd15) begin
            miscompares++; $display("FAIL saturation: got %0d/%0d want 15/15", StallCount, FlushCount);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (StallCount !== 4'd15) begin
            miscompares++; $display("FAIL saturation_hold: got %0d want 15", StallCount);
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 59) != 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RegWriteE  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            ResultSrcE = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 4) == 0);
            MemReqM    = ($urandom_range(0, 2) == 0);
            MemReadyM  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e = exp_comb();
            vectors++;
            if (obs !== e || MemErr !== m_err || StallCount !== m_scnt || FlushCount !== m_fcnt) begin
                miscompares++;
                $display("FAIL random_%0d: got %b err=%b s=%0d f=%0d want %b err=%b s=%0d f=%0d",
                         i, obs, MemErr, StallCount, FlushCount, e, m_err, m_scnt, m_fcnt);
            end
            tick();
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_zero_wait();
        test_mem_3cycle();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
